// File: rtl/prbs_bcd_gen_if.sv
// prbs_bcd_gen_if: control inputs and readout outputs of the PRBS generator.
// The driver uses the master modport and the generator uses the slave modport.
interface prbs_bcd_gen_if #(
  parameter int W      = 16,
  parameter int DIGITS = 5
);
  logic                  en;
  logic                  load;
  logic [W-1:0]          seed_in;
  logic [W-1:0]          lfsr_out;
  logic [4*DIGITS-1:0]   bcd_out;
  logic                  bcd_valid;
  logic                  busy;
  logic                  ovf;

  modport master (
    output en, load, seed_in,
    input  lfsr_out, bcd_out, bcd_valid, busy, ovf
  );

  modport slave (
    input  en, load, seed_in,
    output lfsr_out, bcd_out, bcd_valid, busy, ovf
  );
endinterface

// File: rtl/prbs_bcd_gen.sv
// prbs_bcd_gen: W-bit Fibonacci LFSR with a sequential shift-and-add-3 BCD readout.
// Every LFSR change is flagged as pending. The converter snapshots the newest value
// whenever it is free, so ticks that arrive during a conversion coalesce.
module prbs_bcd_gen #(
  parameter int             W      = 16,
  parameter int             DIGITS = 5,
  parameter logic [W-1:0]   TAPS   = 16'hB400,
  parameter logic [W-1:0]   SEED   = 16'h0001
) (
  input  logic          clk,
  input  logic          rst,
  prbs_bcd_gen_if.slave bus
);
  localparam int BW = 4 * DIGITS;
  localparam int SW = BW + W;
  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {IDLE, CAPTURE, SHIFT, DONE} state_t;

  state_t        state;
  state_t        state_next;
  logic [W-1:0]  lfsr_q;
  logic [W-1:0]  lfsr_step;
  logic [W-1:0]  seed_safe;
  logic          lfsr_change;
  logic          pending_q;
  logic [SW-1:0] shift_q;
  logic [SW-1:0] shift_adj;
  logic [SW-1:0] shift_next;
  logic          carry_out;
  logic [CW-1:0] cnt_q;
  logic          ovf_acc_q;
  logic [BW-1:0] bcd_q;
  logic          ovf_q;
  logic          busy;
  logic          bcd_valid;
  logic          last_shift;

  assign lfsr_step   = {lfsr_q[W-2:0], ^(lfsr_q & TAPS)};
  assign seed_safe   = (bus.seed_in == '0) ? {{(W-1){1'b0}}, 1'b1} : bus.seed_in;
  assign lfsr_change = bus.load | bus.en;
  assign last_shift  = (state == SHIFT) && (cnt_q == CW'(1));

  // LFSR register: a seed load beats a tick, and a zero seed becomes 1 to avoid lock-up
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= SEED;
    end else if (bus.load) begin
      lfsr_q <= seed_safe;
    end else if (bus.en) begin
      lfsr_q <= lfsr_step;
    end
  end

  // Pending flag: set by any LFSR change and cleared when CAPTURE takes its snapshot
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= 1'b1;
    end else if (lfsr_change) begin
      pending_q <= 1'b1;
    end else if (state == CAPTURE) begin
      pending_q <= 1'b0;
    end
  end

  // One double-dabble step: add 3 to every digit >= 5, then shift left; the top bit leaving is overflow
  always_comb begin
    shift_adj = shift_q;
    for (int k = 0; k < DIGITS; k++) begin
      if (shift_q[W + 4*k +: 4] >= 4'd5) begin
        shift_adj[W + 4*k +: 4] = shift_q[W + 4*k +: 4] + 4'd3;
      end
    end
    carry_out  = shift_adj[SW-1];
    shift_next = {shift_adj[SW-2:0], 1'b0};
  end

  // Conversion datapath: load the snapshot in CAPTURE, then iterate once per SHIFT cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q   <= '0;
      cnt_q     <= '0;
      ovf_acc_q <= 1'b0;
    end else begin
      case (state)
        CAPTURE: begin
          shift_q   <= {{BW{1'b0}}, lfsr_q};
          cnt_q     <= CW'(W);
          ovf_acc_q <= 1'b0;
        end
        SHIFT: begin
          shift_q   <= shift_next;
          cnt_q     <= cnt_q - CW'(1);
          ovf_acc_q <= ovf_acc_q | carry_out;
        end
        default: ;
      endcase
    end
  end

  // Result register: updated on the last shift so it is visible together with the DONE pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      bcd_q <= '0;
      ovf_q <= 1'b0;
    end else if (last_shift) begin
      bcd_q <= shift_next[SW-1 -: BW];
      ovf_q <= ovf_acc_q | carry_out;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next state: DONE goes straight back to CAPTURE when a newer value is waiting
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (pending_q) state_next = CAPTURE;
      CAPTURE: state_next = SHIFT;
      SHIFT:   if (cnt_q == CW'(1)) state_next = DONE;
      DONE:    state_next = pending_q ? CAPTURE : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs: busy covers CAPTURE and every SHIFT cycle, and valid is the single DONE cycle
  always_comb begin
    busy      = 1'b0;
    bcd_valid = 1'b0;
    case (state)
      CAPTURE, SHIFT: busy = 1'b1;
      DONE:           bcd_valid = 1'b1;
      default: ;
    endcase
  end

  assign bus.lfsr_out  = lfsr_q;
  assign bus.bcd_out   = bcd_q;
  assign bus.ovf       = ovf_q;
  assign bus.busy      = busy;
  assign bus.bcd_valid = bcd_valid;
endmodule

// File: tb/tb_prbs_bcd_gen.sv
// tb_prbs_bcd_gen: checks a 5-digit and a 4-digit generator driven with identical stimulus.
// A cycle-level reference model built from plain arithmetic is compared every cycle,
// alongside hand-computed vectors and directed corner-case sequences.
module tb_prbs_bcd_gen;
  localparam int          W       = 16;
  localparam logic [15:0] TAPS_TB = 16'hB400;
  localparam logic [15:0] SEED_TB = 16'h0001;

  logic        clk    = 1'b0;
  logic        rst    = 1'b0;
  logic        en_i   = 1'b0;
  logic        load_i = 1'b0;
  logic [15:0] seed_i = 16'h0;

  int n_checks = 0;
  int n_fail   = 0;

  prbs_bcd_gen_if #(.W(16), .DIGITS(5)) bus5 ();
  prbs_bcd_gen_if #(.W(16), .DIGITS(4)) bus4 ();

  assign bus5.en      = en_i;
  assign bus5.load    = load_i;
  assign bus5.seed_in = seed_i;
  assign bus4.en      = en_i;
  assign bus4.load    = load_i;
  assign bus4.seed_in = seed_i;

  prbs_bcd_gen #(.W(16), .DIGITS(5), .TAPS(16'hB400), .SEED(16'h0001)) dut5 (
    .clk (clk),
    .rst (rst),
    .bus (bus5)
  );

  prbs_bcd_gen #(.W(16), .DIGITS(4), .TAPS(16'hB400), .SEED(16'h0001)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  always #5 clk = ~clk;

  // Reference helpers: LFSR step by counting tapped ones, BCD by repeated division
  function automatic logic [15:0] lfsr_ref(input logic [15:0] s);
    int          ones;
    logic [15:0] r;
    ones = 0;
    for (int i = 0; i < 16; i++) if (s[i] && TAPS_TB[i]) ones++;
    r    = s << 1;
    r[0] = (ones % 2) == 1;
    return r;
  endfunction

  function automatic logic [39:0] bcd_ref(input int unsigned v, input int digits);
    logic [39:0] r;
    int unsigned x;
    r = '0;
    x = v;
    for (int d = 0; d < digits; d++) begin
      r[4*d +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic ovf_ref(input int unsigned v, input int digits);
    longint lim;
    lim = 1;
    for (int d = 0; d < digits; d++) lim = lim * 10;
    return longint'(v) >= lim;
  endfunction

  // Reference model state; m_age is cycles since capture began, -1 when idle
  logic [15:0] m_lfsr;
  bit          m_pending;
  int          m_age;
  logic [15:0] m_conv;
  logic [19:0] m_bcd5;
  logic        m_ovf5;
  logic [15:0] m_bcd4;
  logic        m_ovf4;
  bit          m_known = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_lfsr    = SEED_TB;
      m_pending = 1'b1;
      m_age     = -1;
      m_bcd5    = '0;
      m_ovf5    = 1'b0;
      m_bcd4    = '0;
      m_ovf4    = 1'b0;
      m_known   = 1'b1;
    end else if (m_known) begin
      if (m_age == -1) begin
        if (m_pending) m_age = 0;
      end else if (m_age == 0) begin
        m_conv    = m_lfsr;
        m_pending = 1'b0;
        m_age     = 1;
      end else if (m_age < W) begin
        m_age++;
      end else if (m_age == W) begin
        m_age  = W + 1;
        m_bcd5 = 20'(bcd_ref(m_conv, 5));
        m_ovf5 = ovf_ref(m_conv, 5);
        m_bcd4 = 16'(bcd_ref(m_conv, 4));
        m_ovf4 = ovf_ref(m_conv, 4);
      end else begin
        m_age = m_pending ? 0 : -1;
      end
      if (load_i)    m_lfsr = (seed_i == 16'h0) ? 16'h0001 : seed_i;
      else if (en_i) m_lfsr = lfsr_ref(m_lfsr);
      if (en_i || load_i) m_pending = 1'b1;
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic e, input logic l, input logic [15:0] s);
    @(negedge clk);
    rst    = r;
    en_i   = e;
    load_i = l;
    seed_i = s;
  endtask

  task automatic waitValid(input int budget, output int cycles);
    cycles = 0;
    while (bus5.bcd_valid !== 1'b1 && cycles < budget) begin
      @(negedge clk);
      cycles++;
    end
    if (bus5.bcd_valid !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL waitValid: no bcd_valid after %0d cycles, required within %0d", cycles, budget);
    end
  endtask

  // Every-cycle comparison of both instances against the reference model
  always @(negedge clk) begin
    if (m_known) begin
      checkOutput("model lfsr_out", bus5.lfsr_out, m_lfsr);
      checkOutput("model busy", bus5.busy, (m_age >= 0 && m_age <= W));
      checkOutput("model bcd_valid", bus5.bcd_valid, (m_age == W + 1));
      checkOutput("model bcd_out5", bus5.bcd_out, m_bcd5);
      checkOutput("model ovf5", bus5.ovf, m_ovf5);
      checkOutput("model bcd_out4", bus4.bcd_out, m_bcd4);
      checkOutput("model ovf4", bus4.ovf, m_ovf4);
      checkOutput("model bcd_valid4", bus4.bcd_valid, (m_age == W + 1));
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  typedef struct {
    logic        en;
    logic [15:0] seed;
    logic [15:0] lfsr;
    logic [19:0] bcd5;
    logic        ovf5;
    logic [15:0] bcd4;
    logic        ovf4;
  } vec_t;

  vec_t        vecs [8];
  logic [15:0] seq2 [11];
  int          lat;
  int          pulses;
  int          first_c;
  int          second_c;
  logic [19:0] bcd_a;
  logic [19:0] bcd_b;
  logic [15:0] exp3;
  logic        r_r;
  logic        r_e;
  logic        r_l;
  logic [15:0] r_s;

  initial begin
    vecs[0] = '{1'b1, 16'hFFFF, 16'hFFFF, 20'h65535, 1'b0, 16'h5535, 1'b1};
    vecs[1] = '{1'b0, 16'h0000, 16'h0001, 20'h00001, 1'b0, 16'h0001, 1'b0};
    vecs[2] = '{1'b0, 16'h270F, 16'h270F, 20'h09999, 1'b0, 16'h9999, 1'b0};
    vecs[3] = '{1'b0, 16'h2710, 16'h2710, 20'h10000, 1'b0, 16'h0000, 1'b1};
    vecs[4] = '{1'b1, 16'h8000, 16'h8000, 20'h32768, 1'b0, 16'h2768, 1'b1};
    vecs[5] = '{1'b0, 16'h0801, 16'h0801, 20'h02049, 1'b0, 16'h2049, 1'b0};
    vecs[6] = '{1'b0, 16'h1234, 16'h1234, 20'h04660, 1'b0, 16'h4660, 1'b0};
    vecs[7] = '{1'b0, 16'h03E7, 16'h03E7, 20'h00999, 1'b0, 16'h0999, 1'b0};
    seq2 = '{16'h0002, 16'h0004, 16'h0008, 16'h0010, 16'h0020, 16'h0040,
             16'h0080, 16'h0100, 16'h0200, 16'h0400, 16'h0801};

    $display("[TB] reset and automatic seed conversion");
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0);
    checkOutput("reset lfsr_out", bus5.lfsr_out, 16'h0001);
    checkOutput("reset busy", bus5.busy, 1'b0);
    checkOutput("reset bcd_out", bus5.bcd_out, 20'h0);
    checkOutput("reset bcd_valid", bus5.bcd_valid, 1'b0);
    waitValid(40, lat);
    checkOutput("reset latency", lat, 18);
    checkOutput("reset seed bcd", bus5.bcd_out, 20'h00001);
    checkOutput("reset seed ovf", bus5.ovf, 1'b0);
    pulses = 0;
    repeat (40) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 16'h0);
      if (bus5.bcd_valid) pulses++;
    end
    checkOutput("no extra pulse", pulses, 0);

    $display("[TB] LFSR sequence from seed");
    for (int i = 0; i < 11; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 16'h0);
      applyStimulus(1'b0, 1'b0, 1'b0, 16'h0);
      checkOutput($sformatf("lfsr step %0d", i), bus5.lfsr_out, seq2[i]);
      repeat (28) applyStimulus(1'b0, 1'b0, 1'b0, 16'h0);
    end
    checkOutput("sequence final bcd", bus5.bcd_out, 20'h02049);

    $display("[TB] seed load vectors");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, vecs[i].en, 1'b1, vecs[i].seed);
      applyStimulus(1'b0, 1'b0, 1'b0, 16'h0);
      checkOutput($sformatf("vec%0d lfsr", i), bus5.lfsr_out, vecs[i].lfsr);
      waitValid(40, lat);
      checkOutput($sformatf("vec%0d latency", i), lat, 18);
      checkOutput($sformatf("vec%0d bcd5", i), bus5.bcd_out, vecs[i].bcd5);
      checkOutput($sformatf("vec%0d ovf5", i), bus5.ovf, vecs[i].ovf5);
      checkOutput($sformatf("vec%0d valid4", i), bus4.bcd_valid, 1'b1);
      checkOutput($sformatf("vec%0d bcd4", i), bus4.bcd_out, vecs[i].bcd4);
      checkOutput($sformatf("vec%0d ovf4", i), bus4.ovf, vecs[i].ovf4);
    end

    $display("[TB] ticks during busy coalesce");
    applyStimulus(1'b0, 1'b0, 1'b1, 16'hACE1);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0);
    exp3     = lfsr_ref(lfsr_ref(lfsr_ref(16'hACE1)));
    pulses   = 0;
    first_c  = 0;
    second_c = 0;
    bcd_a    = '0;
    bcd_b    = '0;
    for (int c = 1; c <= 50; c++) begin
      applyStimulus(1'b0, (c == 2 || c == 5 || c == 9), 1'b0, 16'h0);
      if (bus5.bcd_valid) begin
        pulses++;
        if (pulses == 1) begin
          first_c = c;
          bcd_a   = bus5.bcd_out;
        end else begin
          second_c = c;
          bcd_b    = bus5.bcd_out;
        end
      end
    end
    checkOutput("coalesce pulse count", pulses, 2);
    checkOutput("coalesce first cycle", first_c, 18);
    checkOutput("coalesce second cycle", second_c, 36);
    checkOutput("coalesce first bcd", bcd_a, 20'h44257);
    checkOutput("coalesce second bcd", bcd_b, 20'(bcd_ref(exp3, 5)));
    checkOutput("coalesce lfsr", bus5.lfsr_out, exp3);

    $display("[TB] reset during conversion");
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h1234);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0);
    pulses = 0;
    for (int c = 1; c <= 9; c++) begin
      applyStimulus((c == 9), (c == 9), (c == 9), 16'h00FF);
      if (bus5.bcd_valid) pulses++;
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0);
    checkOutput("abort no pulse", pulses, 0);
    checkOutput("abort bcd_out", bus5.bcd_out, 20'h0);
    checkOutput("abort busy", bus5.busy, 1'b0);
    checkOutput("abort bcd_valid", bus5.bcd_valid, 1'b0);
    checkOutput("abort lfsr_out", bus5.lfsr_out, 16'h0001);
    checkOutput("abort bcd_out4", bus4.bcd_out, 16'h0);
    waitValid(40, lat);
    checkOutput("abort reconvert latency", lat, 18);
    checkOutput("abort reconvert bcd", bus5.bcd_out, 20'h00001);

    $display("[TB] randomized stimulus against reference model");
    for (int i = 0; i < 3000; i++) begin
      r_r = ($urandom_range(0, 399) == 0);
      r_e = ($urandom_range(0, 11) == 0);
      r_l = ($urandom_range(0, 49) == 0);
      r_s = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
      applyStimulus(r_r, r_e, r_l, r_s);
    end
    repeat (25) applyStimulus(1'b0, 1'b0, 1'b0, 16'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
